// File: rtl/picosoc_irq_ctrl.sv
// picosoc_irq_ctrl: responder-side interrupt controller for the PicoSoC irq/eoi pair.
// It latches external sources as edge- or level-triggered pending bits, gates them with
// ENABLE and the in-service vector, and exposes PENDING/ENABLE/EDGE/FORCE/ACTIVE on iomem.
// Optional feature macro: IRQ_CTRL_SYNC_EN adds a two-flop synchroniser on every src bit,
// so that src may be driven from inputs that are asynchronous to clk.
module picosoc_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter logic [31:0] RSVD_MASK = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] src,
  output logic [31:0] irq,
  input  logic [31:0] eoi,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata
);

  localparam logic [7:0] OFF_PENDING = 8'h00;
  localparam logic [7:0] OFF_ENABLE  = 8'h04;
  localparam logic [7:0] OFF_EDGE    = 8'h08;
  localparam logic [7:0] OFF_FORCE   = 8'h0C;
  localparam logic [7:0] OFF_ACTIVE  = 8'h10;

  logic [31:0] src_in;
  logic [31:0] src_s_q, src_p_q;
  logic [31:0] eoi_q, eoi_p_q;
  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q, enable_d;
  logic [31:0] edge_q, edge_d;
  logic [31:0] irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q;

  logic        accept;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  offset;
  logic [31:0] wmask;
  logic [31:0] w1c_bits;
  logic [31:0] force_bits;
  logic [31:0] edge_evt;
  logic [31:0] eoi_rise;
  logic [31:0] edge_next;
  logic [31:0] level_next;

`ifdef IRQ_CTRL_SYNC_EN
  logic [31:0] sync1_q, sync2_q;

  // Two-flop synchroniser ahead of the source register for asynchronous board inputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_in = sync2_q;
`else
  assign src_in = src;
`endif

  // Source register, its delayed copy for edge detection, and the registered eoi pair.
  // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_s_q <= '0;
      src_p_q <= '0;
      eoi_q   <= '0;
      eoi_p_q <= '0;
    end else begin
      src_s_q <= src_in;
      src_p_q <= src_s_q;
      eoi_q   <= eoi;
      eoi_p_q <= eoi_q;
    end
  end

  assign edge_evt = src_s_q & ~src_p_q;
  assign eoi_rise = eoi_q & ~eoi_p_q;

  // Bus decode: accept an in-window request only when no acknowledge is currently showing.
  assign offset = iomem_addr[7:0];
  assign accept = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]) && !ready_q;
  assign wr_en  = accept && (iomem_wstrb != 4'b0000);
  assign rd_en  = accept && (iomem_wstrb == 4'b0000);
  assign wmask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                   {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};

  // Register writes (lane-masked) and the read multiplexer.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    enable_d   = enable_q;
    edge_d     = edge_q;
    w1c_bits   = '0;
    force_bits = '0;
    rdata_d    = '0;
    if (wr_en) begin
      case (offset)
        OFF_PENDING: w1c_bits   = iomem_wdata & wmask;
        OFF_ENABLE:  enable_d   = (enable_q & ~wmask) | (iomem_wdata & wmask);
        OFF_EDGE:    edge_d     = (edge_q & ~wmask) | (iomem_wdata & wmask);
        OFF_FORCE:   force_bits = iomem_wdata & wmask;
        default:     ;
      endcase
    end
    if (rd_en) begin
      case (offset)
        OFF_PENDING: rdata_d = pending_q;
        OFF_ENABLE:  rdata_d = enable_q;
        OFF_EDGE:    rdata_d = edge_q;
        OFF_ACTIVE:  rdata_d = eoi_q;
        default:     rdata_d = '0;
      endcase
    end
  end

  // Pending update: edge bits hold until retired (sets beat clears); level bits track src_s.
  always_comb begin
    edge_next  = (pending_q & ~(eoi_rise | w1c_bits)) | edge_evt | force_bits;
    level_next = src_s_q | force_bits;
    pending_d  = (edge_q & edge_next) | (~edge_q & level_next);
    irq_d      = pending_q & enable_q & ~eoi_q & ~RSVD_MASK;
  end

  // Architectural registers, registered irq vector and the one-cycle bus acknowledge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      irq_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
      ready_q   <= accept;
    end
  end

  assign irq         = irq_q;
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;

endmodule

// File: tb/tb_picosoc_irq_ctrl.sv
// Self-checking bench for picosoc_irq_ctrl: a table of bus vectors followed by
// hand-written multi-cycle sequences for latency, retire, level, masking, collision,
// out-of-window and reset-during-transfer behaviour.
module tb_picosoc_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int X = 2;
`else
  localparam int X = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] src;
  logic [31:0] irq;
  logic [31:0] eoi;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  picosoc_irq_ctrl #(
    .BASE_ADDR(BASE),
    .RSVD_MASK(32'h0000_0007)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .src         (src),
    .irq         (irq),
    .eoi         (eoi),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  off;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Starts on a negedge; returns on the negedge where the acknowledge is visible.
  task automatic xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic ok);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (iomem_ready) begin
        ok = 1'b1;
        rd = iomem_rdata;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_wdata = '0;
  endtask

  task automatic wr(input string name, input logic [7:0] off, input logic [3:0] wstrb,
                    input logic [31:0] wdata);
    logic [31:0] rd;
    logic        ok;
    xfer(BASE + {24'h0, off}, wstrb, wdata, rd, ok);
    check({name, "_ack"}, {31'h0, ok}, 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ok;
    xfer(BASE + {24'h0, off}, 4'h0, 32'h0, rd, ok);
    check({name, "_ack"}, {31'h0, ok}, 32'h1);
    check(name, rd, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        ok;
    int          seen;

    tbl.push_back('{"pend_rst",   8'h00, 4'h0, 32'h0,         32'h0});
    tbl.push_back('{"en_rst",     8'h04, 4'h0, 32'h0,         32'h0});
    tbl.push_back('{"edge_rst",   8'h08, 4'h0, 32'h0,         32'h0});
    tbl.push_back('{"en_b1_wr",   8'h04, 4'h2, 32'hAABB_CCDD, 32'h0});
    tbl.push_back('{"en_b1",      8'h04, 4'h0, 32'h0,         32'h0000_CC00});
    tbl.push_back('{"en_full_wr", 8'h04, 4'hF, 32'h1234_5678, 32'h0});
    tbl.push_back('{"en_b30_wr",  8'h04, 4'h9, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{"en_b30",     8'h04, 4'h0, 32'h0,         32'hFF34_56FF});
    tbl.push_back('{"edge_wr",    8'h08, 4'hF, 32'hA5A5_A5A5, 32'h0});
    tbl.push_back('{"edge_rd",    8'h08, 4'h0, 32'h0,         32'hA5A5_A5A5});
    tbl.push_back('{"force_wr",   8'h0C, 4'h1, 32'h0000_00FF, 32'h0});
    tbl.push_back('{"pend_force", 8'h00, 4'h0, 32'h0,         32'h0000_00A5});
    tbl.push_back('{"force_rd",   8'h0C, 4'h0, 32'h0,         32'h0});
    tbl.push_back('{"rsvd_14",    8'h14, 4'h0, 32'h0,         32'h0});
    tbl.push_back('{"rsvd_fc",    8'hFC, 4'h0, 32'h0,         32'h0});
    tbl.push_back('{"w1c_b0",     8'h00, 4'h1, 32'h0000_0005, 32'h0});
    tbl.push_back('{"pend_w1c",   8'h00, 4'h0, 32'h0,         32'h0000_00A0});
    tbl.push_back('{"w1c_b1",     8'h00, 4'h2, 32'h0000_FFFF, 32'h0});
    tbl.push_back('{"pend_lane",  8'h00, 4'h0, 32'h0,         32'h0000_00A0});
    tbl.push_back('{"rsvd_wr",    8'h14, 4'hF, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{"en_keep",    8'h04, 4'h0, 32'h0,         32'hFF34_56FF});
    tbl.push_back('{"w1c_all",    8'h00, 4'hF, 32'hFFFF_FFFF, 32'h0});
    tbl.push_back('{"pend_clr",   8'h00, 4'h0, 32'h0,         32'h0});
    tbl.push_back('{"en_zero_wr", 8'h04, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{"edge_z_wr",  8'h08, 4'hF, 32'h0,         32'h0});
    tbl.push_back('{"en_zero",    8'h04, 4'h0, 32'h0,         32'h0});

    resetn      = 1'b0;
    src         = '0;
    eoi         = '0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = '0;
    iomem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_irq",   irq,   32'h0);
    check("rst_ready", {31'h0, iomem_ready}, 32'h0);
    check("rst_rdata", iomem_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Table-driven register vectors; an idle cycle after each also verifies ready dropped.
    foreach (tbl[i]) begin
      xfer(BASE + {24'h0, tbl[i].off}, tbl[i].wstrb, tbl[i].wdata, rd, ok);
      check({tbl[i].name, "_ack"}, {31'h0, ok}, 32'h1);
      if (tbl[i].wstrb == 4'h0) check(tbl[i].name, rd, tbl[i].exp);
      @(negedge clk);
      check({tbl[i].name, "_rdy1"}, {31'h0, iomem_ready}, 32'h0);
    end

    // Edge latch, latency and eoi retire.
    wr("a_en", 8'h04, 4'hF, 32'h30);
    wr("a_edge", 8'h08, 4'hF, 32'h30);
    @(negedge clk);
    src[4] = 1'b1;
    @(negedge clk);
    src[4] = 1'b0;
    repeat (1 + X) @(negedge clk);
    check("edge_lat_early", irq, 32'h0);
    @(negedge clk);
    check("edge_lat", irq, 32'h10);
    repeat (3) @(negedge clk);
    check("edge_held", irq, 32'h10);
    rd_chk("edge_pend", 8'h00, 32'h10);
    eoi[4] = 1'b1;
    @(negedge clk);
    check("eoi_lat_early", irq, 32'h10);
    @(negedge clk);
    check("eoi_mask", irq, 32'h0);
    rd_chk("eoi_retire", 8'h00, 32'h0);
    rd_chk("active_10", 8'h10, 32'h10);
    eoi = '0;
    repeat (3) @(negedge clk);
    check("retired_irq", irq, 32'h0);

    // Level mode: W1C cannot clear while high; drop clears two cycles later.
    wr("b_edge", 8'h08, 4'hF, 32'h0);
    wr("b_en", 8'h04, 4'hF, 32'h20);
    src[5] = 1'b1;
    repeat (3 + X) @(negedge clk);
    check("lvl_irq", irq, 32'h20);
    wr("b_w1c", 8'h00, 4'h1, 32'h20);
    @(negedge clk);
    rd_chk("lvl_w1c_hold", 8'h00, 32'h20);
    src[5] = 1'b0;
    repeat (1 + X) @(negedge clk);
    rd_chk("lvl_drop_hold", 8'h00, 32'h20);
    rd_chk("lvl_drop_clr", 8'h00, 32'h0);
    @(negedge clk);
    check("lvl_irq_off", irq, 32'h0);

    // Masking of reserved bits and in-service sources.
    wr("c_edge", 8'h08, 4'hF, 32'hFFFF_FFFF);
    wr("c_en", 8'h04, 4'hF, 32'hFFFF_FFFF);
    wr("c_force", 8'h0C, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    check("mask_rsvd", irq, 32'hFFFF_FFF8);
    eoi = 32'h0000_0F00;
    repeat (2) @(negedge clk);
    check("mask_eoi", irq, 32'hFFFF_F0F8);
    rd_chk("active_f00", 8'h10, 32'h0000_0F00);
    eoi = '0;
    repeat (3) @(negedge clk);
    check("eoi_retired", irq, 32'hFFFF_F0F8);
    wr("c_w1c", 8'h00, 4'hF, 32'hFFFF_FFFF);
    wr("c_en2", 8'h04, 4'hF, 32'h10);
    wr("c_edge2", 8'h08, 4'hF, 32'h10);
    repeat (2) @(negedge clk);
    check("c_irq_clr", irq, 32'h0);

    // Set/clear collision: edge event and eoi rise in the same cycle, set wins.
    src[4] = 1'b1;
    repeat (X) @(negedge clk);
    eoi[4] = 1'b1;
    repeat (4) @(negedge clk);
    rd_chk("collide_pend", 8'h00, 32'h10);
    check("collide_masked", irq, 32'h0);
    eoi = '0;
    repeat (2) @(negedge clk);
    check("collide_irq", irq, 32'h10);
    src = '0;
    wr("d_w1c", 8'h00, 4'hF, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);

    // Out-of-window access is never acknowledged.
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h100;
    iomem_wstrb = 4'h0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (iomem_ready) seen++;
    end
    iomem_valid = 1'b0;
    check("oow_noack", seen, 32'h0);

    // Reset mid-transfer: ready/rdata/irq drop at once, the pending write is discarded.
    wr("f_force", 8'h0C, 4'hF, 32'h10);
    @(negedge clk);
    check("f_pre_irq", irq, 32'h10);
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h04;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    check("f_pre_ready", {31'h0, iomem_ready}, 32'h1);
    check("f_pre_rdata", iomem_rdata, 32'h10);
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'hFFFF_FFFF;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_irq", irq, 32'h0);
    check("mid_rst_ready", {31'h0, iomem_ready}, 32'h0);
    check("mid_rst_rdata", iomem_rdata, 32'h0);
    repeat (2) @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_wdata = '0;
    resetn = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_en", 8'h04, 32'h0);
    rd_chk("post_rst_pend", 8'h00, 32'h0);
    repeat (2) @(negedge clk);
    check("post_rst_irq", irq, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
